// File: rtl/prog_loader.sv
// Boot-time program loader: receives a framed image over UART (8N1) and writes it
// into the tile RAM, holding the CPU in reset until the image checksum is good.
module prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       load_en,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_wdata,
  output logic       ram_we,
  output logic       cpu_hold,
  output logic       done,
  output logic       err
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SYNC, S_GET_ADDR, S_GET_LEN, S_GET_DATA, S_GET_SUM, S_DONE, S_ERR
  } state_t;

  logic          rx_meta_q, rx_sync_q;
  rx_state_t     rx_st_q, rx_st_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shf_q, shf_d;
  logic          bv_q, bv_d;
  logic          fe_q, fe_d;

  state_t        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    sum_q, sum_d;
  logic [8:0]    cnt_q, cnt_d;

  // UART receiver; held idle while the loader itself is idle
  always_comb begin
    rx_st_d = rx_st_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    shf_d   = shf_q;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
    if (state_q == S_IDLE) begin
      rx_st_d = RX_IDLE;
    end else begin
      case (rx_st_q)
        RX_IDLE: begin
          if (!rx_sync_q) begin
            rx_st_d = RX_START;
            tmr_d   = '0;
          end
        end
        RX_START: begin
          if (tmr_q == HALF_M1) begin
            tmr_d   = '0;
            bit_d   = '0;
            rx_st_d = rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        RX_DATA: begin
          if (tmr_q == FULL_M1) begin
            tmr_d = '0;
            shf_d = {rx_sync_q, shf_q[7:1]};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) rx_st_d = RX_STOP;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        RX_STOP: begin
          if (tmr_q == FULL_M1) begin
            tmr_d   = '0;
            rx_st_d = RX_IDLE;
            bv_d    = rx_sync_q;
            fe_d    = !rx_sync_q;
          end else begin
            tmr_d = tmr_q + TW'(1);
          end
        end
        default: rx_st_d = RX_IDLE;
      endcase
    end
  end

  // Frame parser and RAM write sequencing
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    done_d  = done_q;
    err_d   = err_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    // address advances on the cycle after each write pulse
    if (we_q) addr_d = addr_q + 8'd1;
    if (!load_en) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT_SYNC;
        S_WAIT_SYNC: begin
          if (bv_q && shf_q == SYNC_BYTE) begin
            state_d = S_GET_ADDR;
            sum_d   = 8'd0;
          end
        end
        S_GET_ADDR: begin
          if (fe_q) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (bv_q) begin
            addr_d  = shf_q;
            state_d = S_GET_LEN;
          end
        end
        S_GET_LEN: begin
          if (fe_q) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (bv_q) begin
            cnt_d   = (shf_q == 8'd0) ? 9'd256 : {1'b0, shf_q};
            state_d = S_GET_DATA;
          end
        end
        S_GET_DATA: begin
          if (fe_q) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (bv_q) begin
            wdata_d = shf_q;
            we_d    = 1'b1;
            sum_d   = sum_q + shf_q;
            cnt_d   = cnt_q - 9'd1;
            if (cnt_q == 9'd1) state_d = S_GET_SUM;
          end
        end
        S_GET_SUM: begin
          if (fe_q) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (bv_q) begin
            if (shf_q == sum_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end
          end
        end
        S_DONE:  state_d = S_DONE;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_WAIT_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_st_q   <= RX_IDLE;
      tmr_q     <= '0;
      bit_q     <= '0;
      shf_q     <= '0;
      bv_q      <= 1'b0;
      fe_q      <= 1'b0;
      state_q   <= S_WAIT_SYNC;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      sum_q     <= '0;
      cnt_q     <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_st_q   <= rx_st_d;
      tmr_q     <= tmr_d;
      bit_q     <= bit_d;
      shf_q     <= shf_d;
      bv_q      <= bv_d;
      fe_q      <= fe_d;
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      done_q    <= done_d;
      err_q     <= err_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_we    = we_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_hold  = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected RAM writes are queued as bytes are sent,
// a monitor pops and compares on every ram_we pulse.
module tb_prog_loader;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       load_en;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic       cpu_hold;
  logic       done;
  logic       err;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  prog_loader #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx(rx), .load_en(load_en),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Monitor: every write pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset && ram_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%02h data=%02h, none expected", ram_addr, ram_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (ram_addr !== e.a || ram_wdata !== e.d) begin
          bad++;
          $display("FAIL write: got addr=%02h data=%02h, want addr=%02h data=%02h",
                   ram_addr, ram_wdata, e.a, e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_clk(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(CPB);
    end
    rx = stop;
    wait_clk(CPB);
    rx = 1'b1;
  endtask

  task automatic send_data(input logic [7:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
    send_byte(d, 1'b1);
  endtask

  task automatic restart(input string tag);
    load_en = 1'b0;
    wait_clk(2);
    #1;
    chk({tag, "_idle_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_idle_err"}, 32'(err), 32'd0);
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    load_en = 1'b1;
    wait_clk(2);
  endtask

  task automatic chk_status(input string tag, input logic d, input logic e, input logic h);
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_err"}, 32'(err), 32'(e));
    chk({tag, "_hold"}, 32'(cpu_hold), 32'(h));
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    rx      = 1'b1;
    load_en = 1'b1;
    wait_clk(3);
    #1;
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    wait_clk(3);

    // Basic frame
    send_byte(8'hA5, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h03, 1'b1);
    send_data(8'h10, 8'h11); send_data(8'h11, 8'h22); send_data(8'h12, 8'h33);
    send_byte(8'h66, 1'b1);
    wait_clk(20); #1;
    chk_status("basic", 1'b1, 1'b0, 1'b0);

    // Bad checksum
    restart("r1");
    send_byte(8'hA5, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h03, 1'b1);
    send_data(8'h10, 8'h11); send_data(8'h11, 8'h22); send_data(8'h12, 8'h33);
    send_byte(8'h67, 1'b1);
    wait_clk(20); #1;
    chk_status("badsum", 1'b0, 1'b1, 1'b1);

    // Leading junk then address wrap
    restart("r2");
    send_byte(8'h00, 1'b1); send_byte(8'hFF, 1'b1);
    send_byte(8'hA5, 1'b1); send_byte(8'hFE, 1'b1); send_byte(8'h03, 1'b1);
    send_data(8'hFE, 8'h01); send_data(8'hFF, 8'h02); send_data(8'h00, 8'h03);
    send_byte(8'h06, 1'b1);
    wait_clk(20); #1;
    chk_status("wrap", 1'b1, 1'b0, 1'b0);
    chk("wrap_addr", 32'(ram_addr), 32'h01);

    // Full 256-byte image
    restart("r3");
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    for (int i = 0; i < 256; i++) send_data(8'(i), 8'(i));
    send_byte(8'h80, 1'b1);
    wait_clk(20); #1;
    chk_status("len256", 1'b1, 1'b0, 1'b0);

    // Framing error on second data byte
    restart("r4");
    send_byte(8'hA5, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h03, 1'b1);
    send_data(8'h10, 8'h11);
    send_byte(8'h22, 1'b0);
    wait_clk(30); #1;
    chk_status("frame", 1'b0, 1'b1, 1'b1);

    // One-cycle glitch between bytes must not produce a byte
    restart("r5");
    send_byte(8'hA5, 1'b1);
    wait_clk(8);
    rx = 1'b0;
    wait_clk(1);
    rx = 1'b1;
    wait_clk(20); #1;
    chk("glitch_err", 32'(err), 32'd0);
    send_byte(8'h10, 1'b1); send_byte(8'h01, 1'b1);
    send_data(8'h10, 8'h55);
    send_byte(8'h55, 1'b1);
    wait_clk(20); #1;
    chk_status("glitch", 1'b1, 1'b0, 1'b0);

    // Asynchronous reset during the second data byte
    restart("r6");
    send_byte(8'hA5, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h03, 1'b1);
    send_data(8'h10, 8'h11);
    fork
      send_byte(8'h22, 1'b1);
      begin
        wait_clk(15);
        #2 reset = 1'b1;
        #1;
        chk("arst_we", 32'(ram_we), 32'd0);
        chk("arst_hold", 32'(cpu_hold), 32'd1);
        chk("arst_addr", 32'(ram_addr), 32'd0);
      end
    join
    wait_clk(5);
    @(negedge clk);
    reset = 1'b0;
    wait_clk(5);
    send_byte(8'hA5, 1'b1); send_byte(8'h20, 1'b1); send_byte(8'h02, 1'b1);
    send_data(8'h20, 8'hAA); send_data(8'h21, 8'h55);
    send_byte(8'hFF, 1'b1);
    wait_clk(20); #1;
    chk_status("postrst", 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
